queue_write_arbiter: RTL

Shares the single write port of the game-event message queue among `NUM_REQ` producers, such as the board logic, the input decoder and the timer. It grants one producer at a time, round-robin, and drives a one-cycle `q_write_en` pulse with the granted message. It then waits a fixed settle window and samples `q_write_ack`. Each producer is told whether its message was accepted or rejected because the queue was full, and keeps a saturating count of rejections for debug.

---
 rtl/queue_write_arbiter_if.sv | 26 ++
 rtl/queue_write_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/queue_write_arbiter_if.sv
// Producer/queue handshake bundle for queue_write_arbiter: request side, queue write port and status.
// master is the arbiter's view; slave is the environment (producers plus queue).
interface queue_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int MSG_W   = 24
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*MSG_W-1:0] req_msg;
  logic [NUM_REQ-1:0]       req_done;
  logic [NUM_REQ-1:0]       req_full;
  logic [MSG_W-1:0]         q_write;
  logic                     q_write_en;
  logic                     q_write_ack;
  logic                     busy;
  logic [7:0]               full_count;

  modport master (
    input  req, req_msg, q_write_ack,
    output req_done, req_full, q_write, q_write_en, busy, full_count
  );

  modport slave (
    output req, req_msg, q_write_ack,
    input  req_done, req_full, q_write, q_write_en, busy, full_count
  );
endinterface

// File: rtl/queue_write_arbiter.sv
// Round-robin arbiter sharing the game-event queue write port among NUM_REQ producers.
// Optional QARB_PRIORITY_EN: producer 0 always wins and does not advance the rotation pointer.
module queue_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MSG_W    = 24,
  parameter int ACK_WAIT = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  queue_write_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESOLVE} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] pick_g;
  logic [CNT_W-1:0] cnt;

  function automatic logic [PTR_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                            input logic [PTR_W-1:0]   p);
    logic [PTR_W-1:0] g;
    logic             found;
    int               idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(p) + i) % NUM_REQ;
`ifdef QARB_PRIORITY_EN
      if (!found && idx != 0 && r[idx]) begin
`else
      if (!found && r[idx]) begin
`endif
        found = 1'b1;
        g     = PTR_W'(idx);
      end
    end
`ifdef QARB_PRIORITY_EN
    if (r[0]) g = '0;
`endif
    return g;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g);
    return (g == PTR_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  always_comb pick_g = pick(bus.req, ptr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ptr            <= '0;
      grant          <= '0;
      cnt            <= '0;
      bus.q_write    <= '0;
      bus.q_write_en <= 1'b0;
      bus.req_done   <= '0;
      bus.req_full   <= '0;
      bus.busy       <= 1'b0;
      bus.full_count <= '0;
    end else begin
      bus.q_write_en <= 1'b0;
      bus.req_done   <= '0;
      bus.req_full   <= '0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant          <= pick_g;
            bus.q_write    <= bus.req_msg[int'(pick_g)*MSG_W +: MSG_W];
            bus.q_write_en <= 1'b1;
            bus.busy       <= 1'b1;
            state          <= ISSUE;
          end
        end
        // Strobe cycle; the queue needs ACK_WAIT cycles before its ack is meaningful
        ISSUE: begin
          if (ACK_WAIT == 1) begin
            state <= RESOLVE;
          end else begin
            cnt   <= CNT_W'(ACK_WAIT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) state <= RESOLVE;
          cnt <= cnt - 1'b1;
        end
        RESOLVE: begin
          if (bus.q_write_ack) begin
            bus.req_done[grant] <= 1'b1;
          end else begin
            bus.req_full[grant] <= 1'b1;
            if (bus.full_count != 8'hFF) bus.full_count <= bus.full_count + 8'd1;
          end
`ifdef QARB_PRIORITY_EN
          if (grant != '0) ptr <= next_ptr(grant);
`else
          ptr <= next_ptr(grant);
`endif
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
